mips_regfile: RTL

- General-purpose register file for the MiniMIPS datapath. It sits directly upstream of the ALU (or32/and32/add32 …).
- Two read ports drive ALU operands A and B; one write port accepts the writeback result.
- After reset, a built-in clear sequencer zeroes every register one per cycle, so the storage array needs no reset.

---
 rtl/mips_pkg.sv | 15 +
 rtl/mips_regfile_rdport.sv | 36 +++
 rtl/mips_regfile.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MiniMIPS register-file definitions: default widths, register count and FSM states.
package mips_pkg;

  localparam int unsigned MIPS_DATA_W = 32;
  localparam int unsigned MIPS_ADDR_W = 3;
  localparam int unsigned MIPS_NREG   = 2 ** MIPS_ADDR_W;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/mips_regfile_rdport.sv
// Combinational register-file read mux with $0 and INIT zero-forcing.
// Write-through bypass is compiled in when MIPS_REGFILE_BYPASS_EN is defined.
module mips_regfile_rdport
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = MIPS_DATA_W,
  parameter int unsigned ADDR_W = MIPS_ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] mem_i,
  input  logic                               active_i,
  input  logic                               wr_en_i,
  input  logic [ADDR_W-1:0]                  waddr_i,
  input  logic [DATA_W-1:0]                  wdata_i,
  input  logic [ADDR_W-1:0]                  raddr_i,
  output logic [DATA_W-1:0]                  rdata_o
);

`ifndef MIPS_REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, waddr_i, wdata_i};
`endif

  always_comb begin
    rdata_o = mem_i[raddr_i];
`ifdef MIPS_REGFILE_BYPASS_EN
    if (wr_en_i && (raddr_i == waddr_i)) begin
      rdata_o = wdata_i;
    end
`endif
    // Zero-forcing is applied last so it overrides the bypass.
    if (!active_i || (raddr_i == ADDR_W'(REG_ZERO))) begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/mips_regfile.sv
// MiniMIPS register file: 2 combinational read ports, 1 write port, post-reset clear sequencer.
// Optional same-cycle write-through bypass via MIPS_REGFILE_BYPASS_EN.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = MIPS_DATA_W,
  parameter int unsigned ADDR_W = MIPS_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              ready
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  rf_state_t                     state_q, state_d;
  logic [ADDR_W-1:0]             clr_cnt_q, clr_cnt_d;
  logic                          ready_q, ready_d;
  logic [NREG-1:0][DATA_W-1:0]   mem_q, mem_d;

  logic wr_req;
  logic wr_fire;
  logic active;

  assign wr_req  = we && ready_q;
  assign wr_fire = wr_req && !rst && (waddr != ADDR_W'(REG_ZERO));
  assign active  = (state_q == RF_RUN) && !rst;
  assign ready   = ready_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    mem_d     = mem_q;
    unique case (state_q)
      RF_INIT: begin
        mem_d[clr_cnt_q] = '0;
        clr_cnt_d        = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(NREG - 1)) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end
      end
      RF_RUN: begin
        if (wr_fire) begin
          mem_d[waddr] = wdata;
        end
      end
      default: state_d = RF_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Storage has no reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  mips_regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_a (
    .mem_i    (mem_q),
    .active_i (active),
    .wr_en_i  (wr_req),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr_i  (raddr_a),
    .rdata_o  (rdata_a)
  );

  mips_regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_b (
    .mem_i    (mem_q),
    .active_i (active),
    .wr_en_i  (wr_req),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr_i  (raddr_b),
    .rdata_o  (rdata_b)
  );

endmodule
